// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the inst/data SRAM port arbiter.
// Owner encodings, response tag layout and streak counter width.
package sram_port_arbiter_pkg;

   localparam int unsigned RD_LAT_DEFAULT = 1;
   localparam int unsigned STREAK_W       = 4;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
      logic   cancelled;
   } tag_t;

endpackage

// File: rtl/sram_tag_pipe.sv
// RD_LAT-deep shift register of response tags with a parallel cancel mark.
// The last stage is the tag whose SRAM data is on sram_rdata this cycle.
module sram_tag_pipe
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
   input  logic   clk,
   input  logic   resetn,
   input  logic   push,
   input  owner_e push_owner,
   input  logic   cancel,
   output tag_t   head
);

   tag_t stage_q [RD_LAT];
   tag_t stage_d [RD_LAT];

   always_comb begin
      // A tag entering this cycle belongs to a fetch granted alongside the cancel, so it stays live.
      stage_d[0].vld       = push;
      stage_d[0].owner     = push_owner;
      stage_d[0].cancelled = 1'b0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
         if (cancel && (stage_q[i-1].owner == OWNER_INST)) begin
            stage_d[i].cancelled = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage_q <= '{default: '0};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign head = stage_q[RD_LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between fetch and load/store requesters with
// starvation-bounded data priority and fixed-latency in-order response routing.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned RD_LAT     = RD_LAT_DEFAULT,
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   logic                streak_max;
   logic                gnt_inst;
   logic                gnt_data;
   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   tag_t                head;

   always_comb begin
      streak_max = (streak_q == STREAK_W'(MAX_STREAK));
      gnt_inst   = resetn & inst_req & (~data_req | streak_max);
      gnt_data   = resetn & data_req & ~gnt_inst;
      // Streak only counts data wins that kept a waiting fetch out.
      streak_d   = streak_q;
      if (!inst_req || gnt_inst) begin
         streak_d = '0;
      end else if (gnt_data && !streak_max) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   assign inst_addr_ok = gnt_inst;
   assign data_addr_ok = gnt_data;
   assign sram_en      = gnt_inst | gnt_data;
   assign sram_we      = (gnt_data && data_wr) ? data_wstrb : '0;
   assign sram_addr    = gnt_inst ? inst_addr : data_addr;
   assign sram_wdata   = data_wdata;

   sram_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .resetn     (resetn),
      .push       (gnt_inst | gnt_data),
      .push_owner (gnt_inst ? OWNER_INST : OWNER_DATA),
      .cancel     (inst_cancel),
      .head       (head)
   );

   // The emerging tag is dropped combinationally when the cancel lands on its response cycle.
   assign inst_data_ok = head.vld & (head.owner == OWNER_INST) & ~head.cancelled & ~inst_cancel;
   assign data_data_ok = head.vld & (head.owner == OWNER_DATA);
   assign inst_rdata   = sram_rdata;
   assign data_rdata   = sram_rdata;

endmodule
